// File: rtl/timekeeper_display.sv
// BCD 24h wall clock with debounced set buttons. Renders two 16-char KS0066
// line buffers (char 0 in the low byte) for the downstream LCD controller.
module timekeeper_display #(
  parameter int MFREQ_KHZ   = 1,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         btn_mode,
  input  logic         btn_inc,
  output logic [127:0] line_a,
  output logic [127:0] line_b,
  output logic         tick_1hz,
  output logic [1:0]   mode
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, BAD = 2'd3} mode_e;

  localparam logic [63:0] PRESC_TC = 64'(MFREQ_KHZ) * 64'd1000 - 64'd1;
  localparam logic [63:0] DB_CYC   = 64'(DEBOUNCE_MS) * 64'(MFREQ_KHZ);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Literals are MSB-first; the display wants char 0 in bits [7:0].
  function automatic logic [127:0] to_line(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] dig(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  function automatic logic [127:0] render_a(input logic [7:0] h, input logic [7:0] m,
                                            input logic [7:0] s);
    return to_line({"TIME  ", dig(h[7:4]), dig(h[3:0]), ":", dig(m[7:4]), dig(m[3:0]),
                    ":", dig(s[7:4]), dig(s[3:0]), "  "});
  endfunction

  function automatic logic [127:0] render_b(input mode_e md);
    case (md)
      SET_H:   return to_line("MODE: SET HOUR  ");
      SET_M:   return to_line("MODE: SET MIN   ");
      default: return to_line("MODE: RUN       ");
    endcase
  endfunction

  localparam logic [127:0] LINE_A_RST = to_line("TIME  00:00:00  ");
  localparam logic [127:0] LINE_B_RST = to_line("MODE: RUN       ");

  // Bit 0 carries the mode button, bit 1 the increment button.
  logic [1:0]        sync1_q, sync2_q, acc_q, acc_d, ev;
  logic [1:0][63:0]  db_cnt_q, db_cnt_d;
  logic [63:0]       presc_q, presc_d;
  logic [7:0]        hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  mode_e             mode_q, mode_d;
  logic [127:0]      line_a_q, line_a_d, line_b_q, line_b_d;
  logic              tick;

  assign tick = (presc_q == PRESC_TC);

  always_comb begin
    acc_d    = acc_q;
    db_cnt_d = '0;
    ev       = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != acc_q[b]) begin
        if (db_cnt_q[b] + 64'd1 >= DB_CYC) begin
          acc_d[b] = sync2_q[b];
          ev[b]    = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 64'd1;
        end
      end
    end
  end

  // Within a cycle: inc under the current mode first, then the mode step.
  always_comb begin
    presc_d = tick ? 64'd0 : presc_q + 64'd1;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    mode_d  = mode_q;
    case (mode_q)
      RUN: begin
        if (tick && !ev[0]) begin
          ss_d = bcd_inc(ss_q, 8'h59);
          if (ss_q == 8'h59) begin
            mm_d = bcd_inc(mm_q, 8'h59);
            if (mm_q == 8'h59) hh_d = bcd_inc(hh_q, 8'h23);
          end
        end
        if (ev[0]) mode_d = SET_H;
      end
      SET_H: begin
        if (ev[1]) hh_d = bcd_inc(hh_q, 8'h23);
        if (ev[0]) mode_d = SET_M;
      end
      SET_M: begin
        if (ev[1]) mm_d = bcd_inc(mm_q, 8'h59);
        if (ev[0]) begin
          ss_d    = 8'h00;
          presc_d = 64'd0;
          mode_d  = RUN;
        end
      end
      default: mode_d = RUN;
    endcase
    line_a_d = render_a(hh_d, mm_d, ss_d);
    line_b_d = render_b(mode_d);
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      acc_q    <= '0;
      db_cnt_q <= '0;
      presc_q  <= '0;
      hh_q     <= '0;
      mm_q     <= '0;
      ss_q     <= '0;
      mode_q   <= RUN;
      line_a_q <= LINE_A_RST;
      line_b_q <= LINE_B_RST;
    end else begin
      sync1_q  <= {btn_inc, btn_mode};
      sync2_q  <= sync1_q;
      acc_q    <= acc_d;
      db_cnt_q <= db_cnt_d;
      presc_q  <= presc_d;
      hh_q     <= hh_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
      mode_q   <= mode_d;
      line_a_q <= line_a_d;
      line_b_q <= line_b_d;
    end
  end

  assign line_a   = line_a_q;
  assign line_b   = line_b_q;
  assign tick_1hz = tick;
  assign mode     = mode_q;

endmodule

// File: tb/tb_timekeeper_display.sv
// Bench for timekeeper_display: vector table for button setting plus hand
// sequences for tick timing, rollover, event/tick collision and reset.
module tb_timekeeper_display;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         btn_mode = 1'b0;
  logic         btn_inc = 1'b0;
  logic [127:0] line_a, line_b;
  logic         tick_1hz;
  logic [1:0]   mode;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  timekeeper_display #(.MFREQ_KHZ(1), .DEBOUNCE_MS(2)) dut (
    .mclk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .line_a(line_a), .line_b(line_b), .tick_1hz(tick_1hz), .mode(mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct {
    string        nm;
    int           kind;
    logic [127:0] val;
  } exp_t;

  typedef struct {
    string      nm;
    int         btn;
    int         n;
    int         hold;
    logic [1:0] e_mode;
    string      e_a;
    string      e_b;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];

  function automatic logic [127:0] s2l(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input int kind, input logic [127:0] v);
    sb.push_back('{nm, kind, v});
  endtask

  task automatic push_state(input string nm, input logic [1:0] m, input string a, input string b);
    push_exp({nm, "_mode"}, 2, {126'd0, m});
    push_exp({nm, "_line_a"}, 0, s2l(a));
    push_exp({nm, "_line_b"}, 1, s2l(b));
  endtask

  task automatic drain();
    exp_t e;
    logic [127:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = line_a;
        1:       act = line_b;
        2:       act = {126'd0, mode};
        default: act = {127'd0, tick_1hz};
      endcase
      check(e.nm, act, e.val);
    end
  endtask

  task automatic press(input int btn, input int hold);
    @(posedge clk); #1;
    if (btn == 0) btn_mode = 1'b1;
    else          btn_inc  = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string nm, output int tc);
    tc = -1;
    for (int k = 0; k < 1100 && tc < 0; k++) begin
      @(negedge clk);
      if (tick_1hz) tc = cyc;
    end
    n_cmp++;
    if (tc < 0) begin
      n_bad++;
      $display("FAIL %s: no tick within 1100 cycles", nm);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tq[$];
    int set_c, m_cyc, ft, lat, t, t60, t61, c0, g;

    tbl[0] = '{"pulse1",     0, 1,  1,  2'd0, "TIME  00:00:03  ", "MODE: RUN       "};
    tbl[1] = '{"enter_seth", 0, 1,  10, 2'd1, "TIME  00:00:03  ", "MODE: SET HOUR  "};
    tbl[2] = '{"hh_to_23",   1, 23, 6,  2'd1, "TIME  23:00:03  ", "MODE: SET HOUR  "};
    tbl[3] = '{"hh_wrap",    1, 1,  6,  2'd1, "TIME  00:00:03  ", "MODE: SET HOUR  "};
    tbl[4] = '{"hh_23",      1, 23, 6,  2'd1, "TIME  23:00:03  ", "MODE: SET HOUR  "};
    tbl[5] = '{"enter_setm", 0, 1,  6,  2'd2, "TIME  23:00:03  ", "MODE: SET MIN   "};
    tbl[6] = '{"mm_to_59",   1, 59, 6,  2'd2, "TIME  23:59:03  ", "MODE: SET MIN   "};
    tbl[7] = '{"mm_wrap",    1, 1,  6,  2'd2, "TIME  23:00:03  ", "MODE: SET MIN   "};
    tbl[8] = '{"mm_59",      1, 59, 6,  2'd2, "TIME  23:59:03  ", "MODE: SET MIN   "};

    // Reset state
    repeat (3) @(negedge clk);
    push_state("reset", 2'd0, "TIME  00:00:00  ", "MODE: RUN       ");
    push_exp("reset_tick", 3, 128'd0);
    drain();
    rst = 1'b1;

    // Free run: ticks at 999, 1999, 2999
    tq = '{999, 1999, 2999};
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (tick_1hz) begin
        if (tq.size() > 0) check("tick_cycle", 128'(cyc), 128'(tq.pop_front()));
        else               check("tick_unexpected", {127'd0, tick_1hz}, 128'd0);
      end
      if (cyc == 2999) begin
        push_exp("before_tick3", 0, s2l("TIME  00:00:02  "));
        drain();
      end
      if (cyc == 3000) begin
        push_state("after_tick3", 2'd0, "TIME  00:00:03  ", "MODE: RUN       ");
        drain();
      end
    end
    check("ticks_missing", 128'(tq.size()), 128'd0);

    // Button-driven setting
    for (int v = 0; v < 9; v++) begin
      for (int p = 0; p < tbl[v].n; p++) press(tbl[v].btn, tbl[v].hold);
      push_state(tbl[v].nm, tbl[v].e_mode, tbl[v].e_a, tbl[v].e_b);
      drain();
    end

    // Leave SET_M: seconds clear, next tick a full second after the event
    @(posedge clk); #1;
    btn_mode = 1'b1;
    set_c = cyc;
    m_cyc = -1;
    ft = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 10) btn_mode = 1'b0;
      if (m_cyc < 0 && mode == 2'd0) m_cyc = cyc;
      if (m_cyc >= 0 && ft < 0 && tick_1hz) ft = cyc;
    end
    check("setm_exit_seen", {127'd0, (m_cyc >= 0)}, 128'd1);
    push_state("setm_exit", 2'd0, "TIME  23:59:00  ", "MODE: RUN       ");
    drain();
    lat = (m_cyc >= 0) ? m_cyc - set_c : 4;
    if (ft < 0) wait_tick("first_tick", ft);
    check("tick_after_exit", 128'(ft), 128'(m_cyc + 999));

    // Run up to 23:59:59 then roll over
    t = ft;
    for (int i = 0; i < 58; i++) wait_tick("tick_run", t);
    @(negedge clk);
    push_exp("at_235959", 0, s2l("TIME  23:59:59  "));
    drain();
    wait_tick("tick_roll", t60);
    push_exp("roll_tick_cycle", 0, s2l("TIME  23:59:59  "));
    drain();
    @(negedge clk);
    push_state("rollover", 2'd0, "TIME  00:00:00  ", "MODE: RUN       ");
    drain();

    // Mode event on the same cycle as a tick
    t61 = t60 + 1000;
    c0 = t61 - (lat - 1);
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (cyc < c0 && g < 2000);
    btn_mode = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (cyc < t61 && g < 40);
    push_exp("align_tick", 3, 128'd1);
    drain();
    @(negedge clk);
    push_state("align_mode", 2'd1, "TIME  00:00:00  ", "MODE: SET HOUR  ");
    drain();
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of an inc debounce in SET_H
    press(1, 6);
    push_state("seth_inc", 2'd1, "TIME  01:00:00  ", "MODE: SET HOUR  ");
    drain();
    @(posedge clk); #1;
    btn_inc = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    push_state("rst_async", 2'd0, "TIME  00:00:00  ", "MODE: RUN       ");
    push_exp("rst_async_tick", 3, 128'd0);
    drain();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    push_state("rst_release", 2'd0, "TIME  00:00:00  ", "MODE: RUN       ");
    drain();
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);

    // Inc ignored in RUN
    press(1, 6);
    push_state("run_inc_ignored", 2'd0, "TIME  00:00:00  ", "MODE: RUN       ");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
